round_timer_ctrl: RTL

//  Sequencer for the two-digit BCD countdown timer of the memory tester game.
//  On a round start from the game FSM it loads a level-dependent BCD preset and

---
 rtl/round_timer_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/round_timer_ctrl.sv
// Round timer sequencer: loads a level preset into the BCD countdown timer and paces its decrements.
// Optional low-time warning output is built when ROUND_TIMER_WARN_EN is defined.
module round_timer_ctrl #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter logic [7:0]  PRESET0  = 8'h60,
   parameter logic [7:0]  PRESET1  = 8'h45,
   parameter logic [7:0]  PRESET2  = 8'h30,
   parameter logic [7:0]  PRESET3  = 8'h15
`ifdef ROUND_TIMER_WARN_EN
   ,
   parameter logic [7:0]  WARN_SEC = 8'h10
`endif
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] level,
   input  logic       pause,
   input  logic       abort,
   input  logic       time_stop,
   input  logic [3:0] timedig1,
   input  logic [3:0] timedig2,
   output logic       tmr_stop,
   output logic       tmr_load,
   output logic [7:0] tmr_input_num,
   output logic       tmr_decrement,
   output logic       busy,
   output logic       timeout,
   output logic       warn
);

   localparam int unsigned PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_PAUSE, S_EXPIRE
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    num_q, num_d;
   logic          stop_q, stop_d;
   logic          load_q, load_d;
   logic          dec_q, dec_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;
   logic          expired_c;

   function automatic logic [7:0] preset_sel(input logic [1:0] lv);
      case (lv)
         2'd0:    return PRESET0;
         2'd1:    return PRESET1;
         2'd2:    return PRESET2;
         default: return PRESET3;
      endcase
   endfunction

   assign expired_c = time_stop | ((timedig2 == 4'd0) & (timedig1 == 4'd0));

   // Next state plus next values of every registered output
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      num_d   = num_q;
      dec_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               num_d   = preset_sel(level);
            end
         end
         S_LOAD:   state_d = S_SETTLE;
         // Timer flags are still stale here, so expiry is not looked at
         S_SETTLE: begin
            state_d = S_RUN;
            presc_d = '0;
         end
         S_RUN: begin
            if (expired_c) begin
               state_d = S_EXPIRE;
            end else if (pause) begin
               state_d = S_PAUSE;
            end else if (presc_q == TICK_LAST) begin
               presc_d = '0;
               dec_d   = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         S_PAUSE:  if (!pause) state_d = S_RUN;
         S_EXPIRE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         presc_d = presc_q;
         dec_d   = 1'b0;
      end

      stop_d    = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
                  (state_d == S_RUN)  || (state_d == S_PAUSE);
      load_d    = (state_d == S_LOAD);
      busy_d    = (state_d != S_IDLE);
      timeout_d = (state_d == S_EXPIRE);
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         num_q     <= 8'h00;
         stop_q    <= 1'b0;
         load_q    <= 1'b0;
         dec_q     <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         num_q     <= num_d;
         stop_q    <= stop_d;
         load_q    <= load_d;
         dec_q     <= dec_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign tmr_stop      = stop_q;
   assign tmr_load      = load_q;
   assign tmr_input_num = num_q;
   assign tmr_decrement = dec_q;
   assign busy          = busy_q;
   assign timeout       = timeout_q;

`ifdef ROUND_TIMER_WARN_EN
   // Digits are valid BCD, so a plain unsigned compare orders tens before units
   logic warn_q, warn_d;

   always_comb begin
      warn_d = ((state_d == S_RUN) || (state_d == S_PAUSE)) &&
               ({timedig2, timedig1} <= WARN_SEC);
   end

   always_ff @(posedge clock) begin
      if (!rst) warn_q <= 1'b0;
      else      warn_q <= warn_d;
   end

   assign warn = warn_q;
`else
   assign warn = 1'b0;
`endif

endmodule
